sram_responder: RTL and testbench
=================================

# sram_responder

Memory-side responder for the MEM stage's data-memory requests. Accepts a 32-bit read or write from the MEM stage, performs it as two 16-bit accesses on an external asynchronous SRAM, and holds `ready` low until the access completes so the pipeline can freeze. Data memory is byte-addressed from `BASE_ADDR` and big-endian: the byte at the lowest address is `data[31:24]`.

## Interface
- `BASE_ADDR`, 1024: byte address of data word 0; subtracted from `address`.
- `ACCESS_CYCLES`, 2: cycles per 16-bit SRAM phase; legal values 1..15.
- One clock; reset is synchronous and active-high. Ports `clk`, `rst`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rd_en`  in  1  read request (MEM_R_EN); held stable until `ready`.
- `wr_en`  in  1  write request (MEM_W_EN); held stable until `ready`.
- `address`  in  32  byte address.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data; valid when `ready` is high after a read; held until the next read completes.
- `ready`  out  1  high = no access pending, pipeline may advance; low = freeze.
- `sram_addr`  out  18  SRAM halfword address.
- `sram_dq_out`  out  16  SRAM write data.
- `sram_dq_oe`  out  1  tristate enable for `sram_dq_out`.
- `sram_dq_in`  in  16  SRAM read data.
- `sram_we_n`  out  1  SRAM write strobe, active low.

## Operation
- Address map:
  - offset = `address` − `BASE_ADDR`, 32-bit modulo arithmetic.
  - word index = offset[18:2]. offset[1:0] and offset[31:19] are ignored, so misaligned and out-of-range addresses alias.
  - High phase uses `sram_addr` = {index, 1'b0} and carries bits 31:16.
  - Low phase uses `sram_addr` = {index, 1'b1} and carries bits 15:0.
- States: IDLE, RD_HI, RD_LO, WR_HI, WR_LO, DONE. A 4-bit phase counter counts 0..ACCESS_CYCLES−1.
- IDLE:
  - `rd_en` → RD_HI.
  - else `wr_en` → WR_HI.
  - else stay in IDLE.
  - If `rd_en` and `wr_en` are both high, the read wins and the write is dropped.
  - Request and data are latched on the transition edge; later input changes are ignored until DONE.
- RD_HI / RD_LO:
  - `sram_dq_oe` = 0, `sram_we_n` = 1.
  - `sram_dq_in` is sampled on the edge that ends the last cycle of the phase, into `rdata[31:16]` or `rdata[15:0]` respectively.
  - RD_HI → RD_LO; RD_LO → DONE.
  - `rdata` changes only on those two edges.
- WR_HI / WR_LO:
  - `sram_dq_oe` = 1, `sram_we_n` = 0 for every cycle of the phase.
  - `sram_dq_out` = latched wdata half.
  - WR_HI → WR_LO; WR_LO → DONE.
- DONE: `ready` = 1 for exactly one cycle, then → IDLE unconditionally. A request still high in IDLE is treated as a new access (the pipeline has advanced).
- `ready` = (state == DONE) | (state == IDLE & !rd_en & !wr_en). This is the only combinational output. All SRAM outputs are registered.
- `rst` (any state, including mid-access):
  - → IDLE, counter = 0.
  - `rdata` = 0, `sram_addr` = 0, `sram_dq_out` = 0, `sram_dq_oe` = 0, `sram_we_n` = 1.
  - `ready` = !rd_en & !wr_en.
  - A write interrupted by reset may leave a partial halfword written; this is defined behaviour.

## Timing
- Request first seen high in IDLE at cycle 0 (N = ACCESS_CYCLES):
  - high phase occupies cycles 1..N;
  - low phase occupies cycles N+1..2N;
  - DONE and `ready` high occur in cycle 2N+1.
- With the default N = 2, `ready` is low in cycles 0–4 and high in cycle 5.
- The SRAM address and strobes are stable for the whole phase. Phase changes occur only on clock edges.
- With back-to-back requests, the next access starts in the cycle after DONE, at cycle 2N+2 relative to the previous request. Throughput is one word per 2N+2 cycles.
- No request: `ready` stays high and the SRAM bus stays idle (oe = 0, we_n = 1).

## Test plan
- **Reset:** assert `rst` for 2 cycles with no request → `rdata` = 0, `sram_we_n` = 1, `sram_dq_oe` = 0, `ready` = 1.
- **Write, then read back:**
  - Write 0xDEADBEEF to address 1028.
  - Expect `sram_addr` = 2 with data 0xDEAD for 2 cycles, then `sram_addr` = 3 with 0xBEEF for 2 cycles.
  - `ready` goes high 5 cycles after the request.
  - Reading 1028 then returns `rdata` = 0xDEADBEEF.
- **Simultaneous requests:** `rd_en` = `wr_en` = 1 at address 1024 holding 0x12345678, `wdata` = 0 → read performed, `rdata` = 0x12345678, `sram_we_n` never low, memory unchanged.
- **Reset mid-access:** assert `rst` in the RD_LO phase → next cycle state IDLE, `rdata` = 0. The following read completes normally with 2N+1 latency.
- **Aliasing:** read address 1027 → same data as 1024. Read 1024 + 0x80000 → aliases word 0.
- **Parameter sweep:** ACCESS_CYCLES = 1 → `ready` at cycle 3. ACCESS_CYCLES = 4 → `ready` at cycle 9.

Source files
------------

// File: rtl/sram_responder_if.sv
// MEM-stage data request bus plus the external asynchronous SRAM pins, bundled
// so the responder, the pipeline and an SRAM model can share one connection.
interface sram_responder_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  // Master is the pipeline/board side: issues requests and returns SRAM read data.
  modport master (
    output rd_en, wr_en, address, wdata, sram_dq_in,
    input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport slave (
    input  rd_en, wr_en, address, wdata, sram_dq_in,
    output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_responder.sv
// Data-memory responder: turns one 32-bit big-endian MEM-stage access into two
// 16-bit phases on an asynchronous SRAM, holding ready low until it completes.
module sram_responder #(
  parameter logic [31:0] BASE_ADDR     = 32'd1024,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  sram_responder_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_HI = 3'd1;
  localparam logic [2:0] S_RD_LO = 3'd2;
  localparam logic [2:0] S_WR_HI = 3'd3;
  localparam logic [2:0] S_WR_LO = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

  logic [2:0]  r_state;
  logic [3:0]  r_cnt;
  logic [16:0] r_index;
  logic [15:0] r_wdata_lo;
  logic [31:0] r_rdata;
  logic [17:0] r_sram_addr;
  logic [15:0] r_dq_out;
  logic        r_dq_oe;
  logic        r_we_n;

  logic [31:0] w_offset;
  logic [16:0] w_index;
  logic        w_last;
  logic        w_unused_bits;

  // Misaligned and out-of-range addresses deliberately alias onto the word index.
  assign w_offset      = bus.address - BASE_ADDR;
  assign w_index       = w_offset[18:2];
  assign w_unused_bits = ^{w_offset[31:19], w_offset[1:0]};
  assign w_last        = (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          // A simultaneous read and write performs the read and drops the write.
          if (bus.rd_en) begin
            r_state     <= S_RD_HI;
            r_index     <= w_index;
            r_sram_addr <= {w_index, 1'b0};
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
          end else if (bus.wr_en) begin
            r_state     <= S_WR_HI;
            r_index     <= w_index;
            r_wdata_lo  <= bus.wdata[15:0];
            r_sram_addr <= {w_index, 1'b0};
            r_dq_out    <= bus.wdata[31:16];
            r_dq_oe     <= 1'b1;
            r_we_n      <= 1'b0;
          end
        end
        S_RD_HI: begin
          if (w_last) begin
            r_rdata[31:16] <= bus.sram_dq_in;
            r_sram_addr    <= {r_index, 1'b1};
            r_cnt          <= '0;
            r_state        <= S_RD_LO;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_RD_LO: begin
          if (w_last) begin
            r_rdata[15:0] <= bus.sram_dq_in;
            r_cnt         <= '0;
            r_state       <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_WR_HI: begin
          if (w_last) begin
            r_sram_addr <= {r_index, 1'b1};
            r_dq_out    <= r_wdata_lo;
            r_cnt       <= '0;
            r_state     <= S_WR_LO;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_WR_LO: begin
          if (w_last) begin
            r_dq_oe <= 1'b0;
            r_we_n  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_dq_oe <= 1'b0;
          r_we_n  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready       = (r_state == S_DONE) |
                           ((r_state == S_IDLE) & ~bus.rd_en & ~bus.wr_en);
  assign bus.rdata       = r_rdata;
  assign bus.sram_addr   = r_sram_addr;
  assign bus.sram_dq_out = r_dq_out;
  assign bus.sram_dq_oe  = r_dq_oe;
  assign bus.sram_we_n   = r_we_n;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: three instances (2, 1 and 4 cycles per
// phase) sharing one behavioural SRAM that only the 2-cycle instance writes.
module tb_sram_responder;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  int   we_low;
  int   lat;
  int   we0;

  bit [15:0] mem [0:262143];

  sram_responder_if b2 ();
  sram_responder_if b1 ();
  sram_responder_if b4 ();

  sram_responder #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(2)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
  sram_responder #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  sram_responder #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));

  assign b2.sram_dq_in = mem[b2.sram_addr];
  assign b1.sram_dq_in = mem[b1.sram_addr];
  assign b4.sram_dq_in = mem[b4.sram_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!b2.sram_we_n) begin
      mem[b2.sram_addr] <= b2.sram_dq_out;
      we_low <= we_low + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ready(input int s);
    case (s)
      1:       return b1.ready;
      4:       return b4.ready;
      default: return b2.ready;
    endcase
  endfunction

  function automatic logic [31:0] get_rdata(input int s);
    case (s)
      1:       return b1.rdata;
      4:       return b4.rdata;
      default: return b2.rdata;
    endcase
  endfunction

  task automatic set_req(input int s, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd);
    case (s)
      1:       begin b1.rd_en = rd; b1.wr_en = wr; b1.address = addr; b1.wdata = wd; end
      4:       begin b4.rd_en = rd; b4.wr_en = wr; b4.address = addr; b4.wdata = wd; end
      default: begin b2.rd_en = rd; b2.wr_en = wr; b2.address = addr; b2.wdata = wd; end
    endcase
  endtask

  // Cycles from the request cycle until ready is seen high; 40 means it never came.
  task automatic wait_ready(input int s, output int cycles);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cycles++;
      if (get_ready(s)) break;
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    we_low = 0;
    rst    = 1'b1;
    set_req(1, 0, 0, 0, 0);
    set_req(2, 0, 0, 0, 0);
    set_req(4, 0, 0, 0, 0);

    tick();
    tick();
    check("rst_rdata",  b2.rdata, 32'h0);
    check("rst_we_n",   32'(b2.sram_we_n), 32'd1);
    check("rst_oe",     32'(b2.sram_dq_oe), 32'd0);
    check("rst_addr",   32'(b2.sram_addr), 32'd0);
    check("rst_ready",  32'(b2.ready), 32'd1);
    check("rst_ready1", 32'(b1.ready), 32'd1);
    check("rst_rdata4", b4.rdata, 32'h0);
    rst = 1'b0;
    tick();

    // Write 0xDEADBEEF to 1028, following each phase on the SRAM pins.
    set_req(2, 0, 1, 32'd1028, 32'hDEADBEEF);
    #1;
    check("wr_c0_ready", 32'(b2.ready), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("wr_addr",  32'(b2.sram_addr),   (c <= 2) ? 32'd2 : 32'd3);
      check("wr_dq",    32'(b2.sram_dq_out), (c <= 2) ? 32'h0000DEAD : 32'h0000BEEF);
      check("wr_we_n",  32'(b2.sram_we_n),   32'd0);
      check("wr_oe",    32'(b2.sram_dq_oe),  32'd1);
      check("wr_ready", 32'(b2.ready),       32'd0);
    end
    tick();
    check("wr_c5_ready", 32'(b2.ready), 32'd1);
    check("wr_c5_we_n",  32'(b2.sram_we_n), 32'd1);
    set_req(2, 0, 0, 0, 0);
    tick();
    check("wr_mem_hi", 32'(mem[2]), 32'h0000DEAD);
    check("wr_mem_lo", 32'(mem[3]), 32'h0000BEEF);

    set_req(2, 0, 1, 32'd1024, 32'h12345678);
    wait_ready(2, lat);
    check("wr0_lat", lat, 5);
    set_req(2, 0, 0, 0, 0);
    tick();

    // Read back 1028.
    we0 = we_low;
    set_req(2, 1, 0, 32'd1028, 32'h0);
    wait_ready(2, lat);
    check("rd_lat",   lat, 5);
    check("rd_data",  b2.rdata, 32'hDEADBEEF);
    check("rd_no_we", we_low - we0, 0);
    set_req(2, 0, 0, 0, 0);
    tick();

    // Read and write together: the read wins, memory stays as it was.
    we0 = we_low;
    set_req(2, 1, 1, 32'd1024, 32'h0);
    wait_ready(2, lat);
    check("both_lat",   lat, 5);
    check("both_data",  b2.rdata, 32'h12345678);
    check("both_no_we", we_low - we0, 0);
    check("both_mem0",  32'(mem[0]), 32'h00001234);
    check("both_mem1",  32'(mem[1]), 32'h00005678);
    set_req(2, 0, 0, 0, 0);
    tick();

    // Reset during the low read phase, with the request held across it.
    set_req(2, 1, 0, 32'd1028, 32'h0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_rdata", b2.rdata, 32'h0);
    check("mid_addr",  32'(b2.sram_addr), 32'd0);
    check("mid_we_n",  32'(b2.sram_we_n), 32'd1);
    check("mid_ready", 32'(b2.ready), 32'd0);
    rst = 1'b0;
    wait_ready(2, lat);
    check("mid_lat",  lat, 5);
    check("mid_data", b2.rdata, 32'hDEADBEEF);
    set_req(2, 0, 0, 0, 0);
    tick();

    // Aliasing: byte offset 3 and offset 0x80000 both land on word 0.
    set_req(2, 1, 0, 32'd1027, 32'h0);
    wait_ready(2, lat);
    check("alias3_data", b2.rdata, 32'h12345678);
    set_req(2, 0, 0, 0, 0);
    tick();
    set_req(2, 1, 0, 32'd1028, 32'h0);
    wait_ready(2, lat);
    check("alias_sep", b2.rdata, 32'hDEADBEEF);
    set_req(2, 0, 0, 0, 0);
    tick();
    set_req(2, 1, 0, 32'd1024 + 32'h80000, 32'h0);
    tick();
    check("alias_hi_addr", 32'(b2.sram_addr), 32'd0);
    wait_ready(2, lat);
    check("alias_hi_lat",  lat, 4);
    check("alias_hi_data", b2.rdata, 32'h12345678);
    set_req(2, 0, 0, 0, 0);
    tick();

    // Back-to-back reads: the held request restarts right after DONE.
    set_req(2, 1, 0, 32'd1028, 32'h0);
    wait_ready(2, lat);
    check("b2b_lat0", lat, 5);
    check("b2b_data0", b2.rdata, 32'hDEADBEEF);
    set_req(2, 1, 0, 32'd1024, 32'h0);
    wait_ready(2, lat);
    check("b2b_lat1", lat, 6);
    check("b2b_data1", b2.rdata, 32'h12345678);
    set_req(2, 0, 0, 0, 0);

    // No request: bus idle and ready high.
    tick();
    tick();
    tick();
    check("idle_ready", 32'(b2.ready), 32'd1);
    check("idle_oe",    32'(b2.sram_dq_oe), 32'd0);
    check("idle_we_n",  32'(b2.sram_we_n), 32'd1);

    // Phase length sweep.
    set_req(1, 1, 0, 32'd1024, 32'h0);
    wait_ready(1, lat);
    check("n1_lat",  lat, 3);
    check("n1_data", get_rdata(1), 32'h12345678);
    set_req(1, 0, 0, 0, 0);
    tick();
    set_req(4, 1, 0, 32'd1028, 32'h0);
    wait_ready(4, lat);
    check("n4_lat",  lat, 9);
    check("n4_data", get_rdata(4), 32'hDEADBEEF);
    set_req(4, 0, 0, 0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
